// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and constants for the fetch-address generator.
//   pc_state_e            - controller state encoding (BOOT, RUN, HALTED)
//   PC_INC                - sequential fetch stride in bytes
//   DEFAULT_*             - default width, vectors and return-stack depth
//   misaligned()          - true when a fetch target is not word aligned
package pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } pc_state_e;

    localparam int          PC_INC               = 4;
    localparam int          DEFAULT_XLEN         = 32;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
    localparam int          DEFAULT_RAS_DEPTH    = 4;

    function automatic logic misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/pc_gen_ras.sv
// pc_gen_ras: circular return-address stack (storage, top pointer, count).
//   clk, rst        - clock, asynchronous active-low reset (clears the stack)
//   push, push_data - push a return address
//   pop             - pop the top entry; ignored while the stack is empty
//   top_data        - current top entry
//   empty           - stack holds no entries
// A push onto a full stack overwrites the oldest entry, because the slot
// after the top pointer is the oldest one once the ring has wrapped.
// Pop and push together replace the top in place, leaving depth unchanged.
module pc_gen_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top_data,
    output logic            empty
);

    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   top_ptr;
    logic [PW:0]     count;
    logic            do_pop;

    assign do_pop   = pop && (count != '0);
    assign top_data = mem[top_ptr];
    assign empty    = (count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top_ptr <= '0;
            count   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_pop && push) begin
            mem[top_ptr] <= push_data;
        end else if (do_pop) begin
            top_ptr <= top_ptr - PW'(1);
            count   <= count - (PW+1)'(1);
        end else if (push) begin
            top_ptr                <= top_ptr + PW'(1);
            mem[top_ptr + PW'(1)]  <= push_data;
            if (count != (PW+1)'(DEPTH)) begin
                count <= count + (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: parametrised fetch-address generator.
// Holds the fetch PC, advances it on a fetch_valid/fetch_ready handshake and
// applies trap > redirect > return > advance > hold each cycle.
// Ports:
//   clk, rst                          - clock, asynchronous active-low reset
//   fetch_ready / fetch_valid, pc     - fetch request handshake and address
//   pc_seq                            - pc + 4 (combinational, wraps)
//   redirect_valid, redirect_target   - resolved branch/jump redirect
//   trap_valid, epc                   - trap request, PC captured at last trap
//   misalign                          - one-cycle pulse on misaligned redirect
//   halt_req, halted                  - stop fetching / halted status
//   call_valid, call_ret_addr         - push a return address
//   ret_valid, ras_empty              - pop and redirect, stack empty status
// Macro PC_GEN_RAS_EN: when defined, a RAS_DEPTH-entry return-address stack
// is built; otherwise call/ret are ignored and ras_empty is tied high.
//
// state   | meaning
// --------+----------------------------------------------------------
// BOOT    | first cycle after reset; no fetch, requests ignored
// RUN     | issuing fetches, pc advances on handshake
// HALTED  | fetch stopped; trap resumes, redirect only moves pc
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
    parameter int              RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_seq,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    output logic [XLEN-1:0] epc,
    output logic            misalign,
    input  logic            halt_req,
    output logic            halted,
    input  logic            call_valid,
    input  logic [XLEN-1:0] call_ret_addr,
    input  logic            ret_valid,
    output logic            ras_empty
);

    pc_state_e       state;
    logic            active;
    logic            redir_bad;
    logic            ret_hit;
    logic [XLEN-1:0] ras_top;

    assign pc_seq    = pc + XLEN'(PC_INC);
    assign active    = (state != ST_BOOT);
    assign redir_bad = redirect_valid && misaligned(redirect_target[1:0]);

`ifdef PC_GEN_RAS_EN
    logic ras_push;
    logic ras_pop;

    // The stack only pops when the return actually steers pc.
    assign ras_push = active && call_valid;
    assign ras_pop  = active && ret_valid && !trap_valid && !redirect_valid;
    assign ret_hit  = ret_valid && !ras_empty;

    pc_gen_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (call_ret_addr),
        .top_data  (ras_top),
        .empty     (ras_empty)
    );
`else
    logic unused_ras;

    assign unused_ras = ^{call_valid, call_ret_addr, ret_valid};
    assign ret_hit    = 1'b0;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_BOOT;
            pc          <= RESET_VECTOR;
            epc         <= '0;
            fetch_valid <= 1'b0;
            halted      <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            misalign <= 1'b0;

            // Next pc: trap > redirect > return > advance > hold.
            if (active) begin
                if (trap_valid) begin
                    pc  <= TRAP_VECTOR;
                    epc <= pc;
                end else if (redir_bad) begin
                    pc       <= TRAP_VECTOR;
                    epc      <= redirect_target;
                    misalign <= 1'b1;
                end else if (redirect_valid) begin
                    pc <= redirect_target;
                end else if (ret_hit) begin
                    pc <= ras_top;
                end else if (fetch_valid && fetch_ready) begin
                    pc <= pc_seq;
                end
            end

            // Misaligned redirects behave as traps, including leaving HALTED.
            case (state)
                ST_BOOT: begin
                    state       <= ST_RUN;
                    fetch_valid <= 1'b1;
                    halted      <= 1'b0;
                end
                ST_RUN: begin
                    if (!trap_valid && !redir_bad && halt_req) begin
                        state       <= ST_HALTED;
                        fetch_valid <= 1'b0;
                        halted      <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (trap_valid || redir_bad ||
                        (!redirect_valid && !halt_req)) begin
                        state       <= ST_RUN;
                        fetch_valid <= 1'b1;
                        halted      <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_BOOT;
                    fetch_valid <= 1'b0;
                    halted      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed bench for pc_gen with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] pc;
    logic [31:0] pc_seq;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic [31:0] epc;
    logic        misalign;
    logic        halt_req;
    logic        halted;
    logic        call_valid;
    logic [31:0] call_ret_addr;
    logic        ret_valid;
    logic        ras_empty;

    int checks = 0;
    int errors = 0;

    pc_gen dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_ready     (fetch_ready),
        .fetch_valid     (fetch_valid),
        .pc              (pc),
        .pc_seq          (pc_seq),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .epc             (epc),
        .misalign        (misalign),
        .halt_req        (halt_req),
        .halted          (halted),
        .call_valid      (call_valid),
        .call_ret_addr   (call_ret_addr),
        .ret_valid       (ret_valid),
        .ras_empty       (ras_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        redirect_valid  = 1'b0;
        redirect_target = '0;
        trap_valid      = 1'b0;
        halt_req        = 1'b0;
        call_valid      = 1'b0;
        call_ret_addr   = '0;
        ret_valid       = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        redirect_valid  = 1'b1;
        redirect_target = tgt;
        step();
        redirect_valid  = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        fetch_ready = 1'b1;
        idle_inputs();
        #12;
        check("rst_pc", pc, 32'h0);
        check("rst_fv", {31'd0, fetch_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_epc", epc, 32'h0);
        check("rst_ras_empty", {31'd0, ras_empty}, 32'd1);

        // Release reset between edges; BOOT holds pc, then 0,4,8,12.
        rst = 1'b1;
        step();
        check("boot_pc", pc, 32'h0);
        check("boot_fv", {31'd0, fetch_valid}, 32'd1);
        step(); check("seq_4", pc, 32'h4);
        step(); check("seq_8", pc, 32'h8);
        step(); check("seq_c", pc, 32'hC);

        // Asynchronous reset mid-run.
        #2 rst = 1'b0;
        #1;
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_fv", {31'd0, fetch_valid}, 32'd0);
        #2 rst = 1'b1;
        step(); check("reboot_pc", pc, 32'h0);
        step(); check("reseq_4", pc, 32'h4);
        step(); check("reseq_8", pc, 32'h8);

        // Stall for three cycles at pc = 8.
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold", pc, 32'h8);
        end

        // Redirect to 0x40 then advance.
        redirect_to(32'h40);
        check("redir_40", pc, 32'h40);
        fetch_ready = 1'b1;
        step(); check("redir_44", pc, 32'h44);
        check("pc_seq_48", pc_seq, 32'h48);

        // Trap beats a simultaneous redirect.
        fetch_ready = 1'b0;
        redirect_to(32'h20);
        check("at_20", pc, 32'h20);
        trap_valid      = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h80;
        step();
        idle_inputs();
        check("trap_pc", pc, 32'h100);
        check("trap_epc", epc, 32'h20);
        check("trap_no_misalign", {31'd0, misalign}, 32'd0);

        // Misaligned redirect becomes a trap with a one-cycle pulse.
        redirect_to(32'h42);
        check("mis_pc", pc, 32'h100);
        check("mis_epc", epc, 32'h42);
        check("mis_pulse", {31'd0, misalign}, 32'd1);
        step();
        check("mis_pulse_end", {31'd0, misalign}, 32'd0);
        check("mis_pc_hold", pc, 32'h100);

        // Halt with a completing handshake still advances.
        redirect_to(32'h10);
        check("at_10", pc, 32'h10);
        fetch_ready = 1'b1;
        halt_req    = 1'b1;
        step();
        check("halt_pc", pc, 32'h14);
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_fv", {31'd0, fetch_valid}, 32'd0);
        step();
        check("halt_hold", pc, 32'h14);
        halt_req = 1'b0;
        step();
        check("resume_flag", {31'd0, halted}, 32'd0);
        check("resume_pc", pc, 32'h14);
        step();
        check("resume_18", pc, 32'h18);

        // Redirect while halted moves pc but stays halted; trap resumes.
        halt_req = 1'b1;
        step();
        check("halt2_pc", pc, 32'h1C);
        redirect_to(32'h60);
        check("halted_redir_pc", pc, 32'h60);
        check("halted_redir_flag", {31'd0, halted}, 32'd1);
        halt_req   = 1'b0;
        trap_valid = 1'b1;
        step();
        trap_valid = 1'b0;
        check("halt_trap_pc", pc, 32'h100);
        check("halt_trap_epc", epc, 32'h60);
        check("halt_trap_flag", {31'd0, halted}, 32'd0);

        // Wrap-around at the top of the address space.
        fetch_ready = 1'b0;
        redirect_to(32'hFFFF_FFFC);
        check("wrap_seq", pc_seq, 32'h0);
        fetch_ready = 1'b1;
        step();
        check("wrap_pc", pc, 32'h0);

        // Return-address stack.
        fetch_ready = 1'b0;
        redirect_to(32'h200);
        for (int i = 1; i <= 5; i++) begin
            call_valid    = 1'b1;
            call_ret_addr = 32'(i * 16);
            step();
        end
        call_valid = 1'b0;
        check("push_pc_hold", pc, 32'h200);
`ifdef PC_GEN_RAS_EN
        check("ras_not_empty", {31'd0, ras_empty}, 32'd0);
        ret_valid = 1'b1;
        for (int i = 5; i >= 2; i--) begin
            step();
            check("ret_pc", pc, 32'(i * 16));
        end
        step();
        ret_valid = 1'b0;
        check("ret_empty_pc", pc, 32'h20);
        check("ras_empty_end", {31'd0, ras_empty}, 32'd1);
`else
        check("ras_tied_empty", {31'd0, ras_empty}, 32'd1);
        ret_valid = 1'b1;
        step();
        ret_valid = 1'b0;
        check("ret_ignored", pc, 32'h200);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
